// File: rtl/xdisp_queue.sv
// ---------------------------------------------------------------------------
// xdisp_queue
// Write-side buffer for the 7-segment display peripheral. CPU writes of
// 11-bit two's-complement values are queued in a small circular FIFO. Each
// value is handed to the display driver with a one-cycle strobe and then
// held for HOLD_CYCLES cycles before the next value may be presented.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   sel        in   module select from the address decoder
//   wr_en      in   CPU write strobe (write requested when sel & wr_en)
//   wr_data    in   [10:0] value to display, passed through bit-exact
//   disp_data  out  [10:0] value presented to the driver (registered)
//   disp_sel   out  one-cycle strobe when disp_data is first valid
//   empty      out  FIFO holds no entries
//   full       out  FIFO holds DEPTH entries
//   count      out  [$clog2(DEPTH):0] FIFO occupancy
//   ovf        out  sticky: a write was dropped because the FIFO was full
//   busy       out  presentation FSM is holding a value
// ---------------------------------------------------------------------------
module xdisp_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic                     wr_en,
  input  logic [10:0]              wr_data,
  output logic [10:0]              disp_data,
  output logic                     disp_sel,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(HOLD_CYCLES);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_ZERO = CW'(0);
  localparam logic [NW-1:0] CNT_FULL  = NW'(DEPTH);
  localparam logic [NW-1:0] CNT_ZERO  = NW'(0);
  localparam logic [NW-1:0] CNT_ONE   = NW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [10:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [NW-1:0]  count_r;
  logic           empty_r;
  logic           full_r;
  logic           ovf_r;
  logic [0:0]     state_r;
  logic [CW-1:0]  hold_r;
  logic           busy_r;
  logic [10:0]    disp_data_r;
  logic           disp_sel_r;

  logic           wr_req_s;
  logic           wr_acc_s;
  logic           pop_s;
  logic [0:0]     state_nx_s;
  logic [CW-1:0]  hold_nx_s;
  logic [NW-1:0]  count_nx_s;

  // A write is judged against the registered full flag, i.e. before any pop
  // happening at the same edge, so a full FIFO drops the write even then.
  assign wr_req_s = sel & wr_en;
  assign wr_acc_s = wr_req_s & ~full_r;

  // Presentation FSM: decides when to pop and reloads the hold counter.
  always_comb begin
    state_nx_s = state_r;
    hold_nx_s  = hold_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_r) begin
          pop_s      = 1'b1;
          state_nx_s = ST_HOLD;
          hold_nx_s  = HOLD_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
          hold_nx_s  = HOLD_ZERO;
        end
      end
      ST_HOLD: begin
        if (hold_r != HOLD_ZERO) begin
          hold_nx_s = hold_r - CW'(1);
        end else if (!empty_r) begin
          pop_s      = 1'b1;
          state_nx_s = ST_HOLD;
          hold_nx_s  = HOLD_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
          hold_nx_s  = HOLD_ZERO;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        hold_nx_s  = HOLD_ZERO;
      end
    endcase
  end

  // Occupancy update: a simultaneous write and pop leaves the count unchanged.
  always_comb begin
    count_nx_s = count_r;
    case ({wr_acc_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Control, flags and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      ovf_r       <= 1'b0;
      state_r     <= ST_IDLE;
      hold_r      <= HOLD_ZERO;
      busy_r      <= 1'b0;
      disp_data_r <= 11'd0;
      disp_sel_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        disp_data_r <= mem_r[rd_ptr_r];
      end
      count_r    <= count_nx_s;
      empty_r    <= (count_nx_s == CNT_ZERO);
      full_r     <= (count_nx_s == CNT_FULL);
      ovf_r      <= ovf_r | (wr_req_s & full_r);
      state_r    <= state_nx_s;
      hold_r     <= hold_nx_s;
      busy_r     <= (state_nx_s == ST_HOLD);
      disp_sel_r <= pop_s;
    end
  end

  assign disp_data = disp_data_r;
  assign disp_sel  = disp_sel_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign count     = count_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_xdisp_queue.sv
// ---------------------------------------------------------------------------
// tb_xdisp_queue
// Self-checking bench for xdisp_queue with DEPTH=4, HOLD_CYCLES=4. Expected
// presentations (value and edge number) are queued when writes are driven;
// observed strobes are collected each cycle and matched against them.
// ---------------------------------------------------------------------------
module tb_xdisp_queue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr_en;
  logic [10:0] wr_data;
  logic [10:0] disp_data;
  logic        disp_sel;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        ovf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [10:0] exp_d_q[$];
  int          exp_c_q[$];
  logic [10:0] obs_d_q[$];
  int          obs_c_q[$];

  xdisp_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .wr_data(wr_data),
    .disp_data(disp_data), .disp_sel(disp_sel), .empty(empty), .full(full),
    .count(count), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later, log any presentation strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (disp_sel === 1'b1) begin
      obs_d_q.push_back(disp_data);
      obs_c_q.push_back(cyc);
    end
  endtask

  task automatic expect_pop(input logic [10:0] d, input int c);
    exp_d_q.push_back(d);
    exp_c_q.push_back(c);
  endtask

  task automatic clear_sb();
    exp_d_q.delete(); exp_c_q.delete(); obs_d_q.delete(); obs_c_q.delete();
  endtask

  task automatic test_reset();
    clear_sb();
    rst = 1'b0; sel = 1'b1; wr_en = 1'b1; wr_data = 11'h155;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (count !== 3'd0) begin
        n_err++; $display("FAIL reset_count_held[%0d]: got %0d want 0", i, count);
      end
    end
    n_vec++; if (disp_data !== 11'h000) begin n_err++; $display("FAIL reset_disp_data: got %h want 000", disp_data); end
    n_vec++; if (disp_sel !== 1'b0) begin n_err++; $display("FAIL reset_disp_sel: got %b want 0", disp_sel); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1; sel = 1'b0; wr_en = 1'b0;
    tick();
    n_vec++; if (disp_sel !== 1'b0) begin n_err++; $display("FAIL reset_release_sel: got %b want 0", disp_sel); end
  endtask

  task automatic test_single_write();
    int e0;
    clear_sb();
    sel = 1'b1; wr_en = 1'b1; wr_data = 11'h7FF;
    e0 = cyc + 1;
    expect_pop(11'h7FF, e0 + 1);
    tick();
    sel = 1'b0; wr_en = 1'b0; wr_data = 11'h000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if (disp_sel !== (k == 1)) begin n_err++; $display("FAIL single_sel[E%0d]: got %b want %b", k, disp_sel, (k == 1)); end
      n_vec++;
      if (busy !== (k <= 4)) begin n_err++; $display("FAIL single_busy[E%0d]: got %b want %b", k, busy, (k <= 4)); end
    end
    n_vec++; if (disp_data !== 11'h7FF) begin n_err++; $display("FAIL single_hold_data: got %h want 7ff", disp_data); end
    n_vec++;
    if (obs_d_q.size() != exp_d_q.size()) begin n_err++; $display("FAIL single_npop: got %0d want %0d", obs_d_q.size(), exp_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      logic [10:0] od, ed; int oc, ec;
      od = obs_d_q.pop_front(); oc = obs_c_q.pop_front();
      ed = exp_d_q.pop_front(); ec = exp_c_q.pop_front();
      n_vec++; if (od !== ed) begin n_err++; $display("FAIL single_pop_data: got %h want %h", od, ed); end
      n_vec++; if (oc != ec) begin n_err++; $display("FAIL single_pop_edge: got %0d want %0d", oc, ec); end
    end
  endtask

  task automatic test_burst();
    logic [10:0] vals [3];
    int e0;
    clear_sb();
    vals[0] = 11'h005; vals[1] = 11'h00A; vals[2] = 11'h7FD;
    e0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      sel = 1'b1; wr_en = 1'b1; wr_data = vals[i];
      expect_pop(vals[i], e0 + 1 + HOLD * i);
      tick();
    end
    sel = 1'b0; wr_en = 1'b0;
    while (cyc < e0 + 9) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL burst_empty_after_e9: got %b want 1", empty); end
    while (cyc < e0 + 14) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_idle: got %b want 0", busy); end
    n_vec++;
    if (obs_d_q.size() != exp_d_q.size()) begin n_err++; $display("FAIL burst_npop: got %0d want %0d", obs_d_q.size(), exp_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      logic [10:0] od, ed; int oc, ec;
      od = obs_d_q.pop_front(); oc = obs_c_q.pop_front();
      ed = exp_d_q.pop_front(); ec = exp_c_q.pop_front();
      n_vec++; if (od !== ed) begin n_err++; $display("FAIL burst_pop_data: got %h want %h", od, ed); end
      n_vec++; if (oc != ec) begin n_err++; $display("FAIL burst_pop_edge: got %0d want %0d", oc, ec); end
    end
  endtask

  task automatic test_unselected();
    clear_sb();
    sel = 1'b0; wr_en = 1'b1; wr_data = 11'h123;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL unsel_count[%0d]: got %0d want 0", i, count); end
      n_vec++; if (disp_sel !== 1'b0) begin n_err++; $display("FAIL unsel_sel[%0d]: got %b want 0", i, disp_sel); end
    end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL unsel_ovf: got %b want 0", ovf); end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [10:0] w [6];
    int e0;
    clear_sb();
    w[0] = 11'h001; w[1] = 11'h400; w[2] = 11'h3FF;
    w[3] = 11'h555; w[4] = 11'h2AA; w[5] = 11'h7C0;
    e0 = cyc + 1;
    for (int i = 0; i < 5; i++) expect_pop(w[i], e0 + 1 + HOLD * i);
    for (int i = 0; i < 6; i++) begin
      sel = 1'b1; wr_en = 1'b1; wr_data = w[i];
      tick();
      if (i == 4) begin
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full_e4: got %b want 1", full); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf); end
      end
      if (i == 5) begin
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_e5: got %b want 1", ovf); end
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL ovf_count_e5: got %0d want 3", count); end
      end
    end
    sel = 1'b0; wr_en = 1'b0;
    while (cyc < e0 + 23) tick();
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    n_vec++;
    if (obs_d_q.size() != exp_d_q.size()) begin n_err++; $display("FAIL ovf_npop: got %0d want %0d", obs_d_q.size(), exp_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      logic [10:0] od, ed; int oc, ec;
      od = obs_d_q.pop_front(); oc = obs_c_q.pop_front();
      ed = exp_d_q.pop_front(); ec = exp_c_q.pop_front();
      n_vec++; if (od !== ed) begin n_err++; $display("FAIL ovf_pop_data: got %h want %h", od, ed); end
      n_vec++; if (oc != ec) begin n_err++; $display("FAIL ovf_pop_edge: got %0d want %0d", oc, ec); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int e0;
    clear_sb();
    e0 = cyc + 1;
    sel = 1'b1; wr_en = 1'b1; wr_data = 11'h0F0;
    expect_pop(11'h0F0, e0 + 1);
    tick();
    wr_data = 11'h70F;
    tick();
    sel = 1'b0; wr_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (disp_data !== 11'h000) begin n_err++; $display("FAIL midrst_data: got %h want 000", disp_data); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    sel = 1'b1; wr_en = 1'b1; wr_data = 11'h246;
    expect_pop(11'h246, cyc + 2);
    tick();
    sel = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_vec++;
    if (obs_d_q.size() != exp_d_q.size()) begin n_err++; $display("FAIL midrst_npop: got %0d want %0d", obs_d_q.size(), exp_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      logic [10:0] od, ed; int oc, ec;
      od = obs_d_q.pop_front(); oc = obs_c_q.pop_front();
      ed = exp_d_q.pop_front(); ec = exp_c_q.pop_front();
      n_vec++; if (od !== ed) begin n_err++; $display("FAIL midrst_pop_data: got %h want %h", od, ed); end
      n_vec++; if (oc != ec) begin n_err++; $display("FAIL midrst_pop_edge: got %0d want %0d", oc, ec); end
    end
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; wr_en = 1'b0; wr_data = 11'h000;
    test_reset();
    test_single_write();
    test_burst();
    test_unselected();
    test_overflow();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xdisp_queue.md
# xdisp_queue

Write-side buffer for the 7-segment display peripheral. Accepts 11-bit signed display values from the CPU peripheral bus into a small FIFO. Presents each value to the display driver with a one-cycle select strobe, then holds it for a programmable number of cycles so every value stays readable. It sits between the address decoder/CPU write port and the display driver: `disp_data`/`disp_sel` connect to the driver's `data_in`/`sel`.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `HOLD_CYCLES`, 50_000_000: cycles between successive value presentations; ≥2.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `sel`, in, 1: module selection from the address decoder.
- `wr_en`, in, 1: CPU write strobe; a write is only requested when `sel & wr_en`.
- `wr_data`, in, 11: value to display, two's complement, bit 10 = sign.
- `disp_data`, out, 11: value currently presented to the display driver (registered).
- `disp_sel`, out, 1: one-cycle strobe; high in the single cycle a new `disp_data` is first valid (registered).
- `empty`, out, 1: FIFO holds 0 entries.
- `full`, out, 1: FIFO holds `DEPTH` entries.
- `count`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `ovf`, out, 1: sticky flag for a dropped write; cleared only by reset.
- `busy`, out, 1: FSM is in HOLD.

## Operation

- FIFO: circular buffer with read/write pointers that wrap at `DEPTH`, plus an occupancy counter.
- Write accepted at an edge when `sel & wr_en & !full`. `full` is sampled before any pop in the same cycle.
- Write with `sel & wr_en & full`: data dropped, `ovf` set to 1, FIFO unchanged. This applies even if a pop occurs at the same edge.
- Simultaneous accepted write and pop: `count` unchanged, both pointers advance.
- FSM states:
  - IDLE: if `!empty`, pop the head into `disp_data`, assert `disp_sel`, load the hold counter with `HOLD_CYCLES-1`, and go to HOLD. Otherwise stay in IDLE.
  - HOLD: decrement the counter each cycle. When the counter = 0:
    - if `!empty`, pop the next value (same actions as IDLE pop) and stay in HOLD;
    - else go to IDLE.
- `disp_sel` deasserts the cycle after every pop.
- `disp_data` is never modified except by a pop or by reset. It retains the last value indefinitely in IDLE.
- No arithmetic on data: values pass through bit-exact. Sign handling belongs to the display driver.
- Reset (`rst`=0 at an edge) has priority over everything:
  - pointers and `count` = 0;
  - FSM state = IDLE, hold counter = 0.
  - FIFO contents need not be cleared.

## Timing

- Output values after reset: `disp_data`=0, `disp_sel`=0, `empty`=1, `full`=0, `count`=0, `ovf`=0, `busy`=0.
- Latency: write accepted at edge E0 into an empty FIFO with FSM in IDLE → pop at E1. `disp_sel`=1 and new `disp_data` valid between E1 and E2.
- Back-to-back pops are exactly `HOLD_CYCLES` edges apart while the FIFO stays non-empty.
- After the last pop, the FSM returns to IDLE at pop edge + `HOLD_CYCLES`. A value written during HOLD is popped no earlier than that same edge.
- `empty`, `full`, `count` and `ovf` update on the same edge as the write/pop/drop that changes them.
- Reset mid-HOLD:
  - the hold is abandoned, queued values are lost, and `disp_data` returns to 0;
  - no `disp_sel` pulse appears on the reset edge or the following cycle.
- `sel=0` or `wr_en=0`: no write and no flag change, regardless of `wr_data`.

## Test plan

All scenarios use `DEPTH`=4 and `HOLD_CYCLES`=4.

- **Reset:** hold `rst`=0 for 3 edges with `sel=wr_en=1` → after reset, all outputs at the listed reset values, and `count` stays 0 until `rst`=1.
- **Single write:** write `wr_data`=0x7FF at E0 → `disp_sel`=1 only between E1 and E2 with `disp_data`=0x7FF; `busy`=1 from E1; FSM back in IDLE (`busy`=0) after E5; `disp_data` still 0x7FF.
- **Ordered burst:** writes 0x005, 0x00A, 0x7FD at E0–E2 → `disp_sel` pulses at E1, E5, E9 with `disp_data` 0x005, 0x00A, 0x7FD in that order; `empty`=1 after E9.
- **Overflow:** writes w1–w6 at consecutive edges E0–E5 → w1 popped at E1; `full`=1 after E4; w6 at E5 is dropped (full sampled before the E5 pop of w2) and `ovf`=1 from E5; later pops deliver w3, w4, w5; w6 never appears.
- **Unselected write:** `wr_en`=1, `sel`=0, `wr_data`=0x123 for 10 cycles → `count`=0, `disp_sel` never asserts, `ovf`=0.
- **Reset mid-HOLD:** two values queued, first popped; assert `rst`=0 two cycles into HOLD → `disp_data`=0, `count`=0, `busy`=0; no further `disp_sel` until a new write.
